// File: rtl/i2c_master_burst.sv
`timescale 1ns/1ps
// Burst I2C master: multi-byte writes/reads to a 7-bit slave, SCL derived from clk by an
// elaboration-time divider, open-drain SDA/SCL with slave clock-stretch support.
module i2c_master_burst #(
   parameter int SYS_CLK_HZ = 50_000_000,
   parameter int I2C_HZ     = 100_000,
   parameter int LEN_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dataValid,
   input  logic             rw,
   input  logic [6:0]       addr,
   input  logic [LEN_W-1:0] numBytes,
   input  logic [7:0]       din,
   output logic             dinReq,
   output logic [7:0]       dout,
   output logic             doutValid,
   output logic             busy,
   output logic             ackErr,
   output logic             done,
   inout  wire              sda,
   inout  wire              scl
);

   localparam int DIV = SYS_CLK_HZ / (4 * I2C_HZ);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   if (DIV < 1) begin : gDivCheck
      $error("i2c_master_burst: SYS_CLK_HZ must be at least 4*I2C_HZ");
   end

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP
   } state_t;

   state_t           state;
   logic [DW-1:0]    divCnt;
   logic [1:0]       phase;
   logic [2:0]       bitCnt;
   logic [LEN_W-1:0] byteCnt;
   logic [7:0]       shiftReg;
   logic [7:0]       dataReg;
   logic             rwReg;
   logic             ackBit;
   logic             bitState;
   logic             stretch;
   logic             phaseEnd;
   logic             bitEnd;
   logic             sampleNow;
   logic             ackSeen;
   logic             lastByte;
   logic             sdaLow;
   logic             sclLow;

   // Only data/ACK bits honour stretching; the phase counter freezes while SCL is held low in ph2.
   assign bitState  = state inside {ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK};
   assign stretch   = bitState && (phase == 2'd2) && !scl;
   assign phaseEnd  = !stretch && (divCnt == DIV_LAST);
   assign bitEnd    = phaseEnd && (phase == 2'd3);
   assign sampleNow = (phase == 2'd3) && (divCnt == '0);
   assign ackSeen   = sampleNow ? sda : ackBit;
   assign lastByte  = (byteCnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         divCnt    <= '0;
         phase     <= 2'd0;
         bitCnt    <= 3'd0;
         byteCnt   <= '0;
         shiftReg  <= 8'h00;
         dataReg   <= 8'h00;
         rwReg     <= 1'b0;
         ackBit    <= 1'b0;
         dinReq    <= 1'b0;
         dout      <= 8'h00;
         doutValid <= 1'b0;
         busy      <= 1'b0;
         ackErr    <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         dinReq    <= 1'b0;
         doutValid <= 1'b0;
         if (dinReq)
            dataReg <= din;
         if (state == IDLE) begin
            if (dataValid && !done) begin
               state    <= START;
               busy     <= 1'b1;
               rwReg    <= rw;
               shiftReg <= {addr, rw};
               dataReg  <= din;
               byteCnt  <= numBytes;
               ackErr   <= 1'b0;
               divCnt   <= '0;
               phase    <= 2'd0;
               bitCnt   <= 3'd0;
            end
         end else begin
            if (!stretch)
               divCnt <= phaseEnd ? '0 : divCnt + DW'(1);
            if (phaseEnd)
               phase <= phase + 2'd1;

            if (sampleNow) begin
               if (state == ADDR_ACK || state == WR_ACK)
                  ackBit <= sda;
               if (state == RD_DATA) begin
                  shiftReg <= {shiftReg[6:0], sda};
                  if (bitCnt == 3'd7) begin
                     dout      <= {shiftReg[6:0], sda};
                     doutValid <= 1'b1;
                  end
               end
            end

            // Bit boundaries drive the state walk; write data is always sourced from dataReg.
            if (bitEnd) begin
               case (state)
                  START: begin
                     state  <= ADDR;
                     bitCnt <= 3'd0;
                  end
                  ADDR, WR_DATA: begin
                     if (bitCnt == 3'd7) begin
                        bitCnt <= 3'd0;
                        if (state == ADDR) begin
                           state <= ADDR_ACK;
                        end else begin
                           state  <= WR_ACK;
                           dinReq <= !lastByte;
                        end
                     end else begin
                        bitCnt   <= bitCnt + 3'd1;
                        shiftReg <= {shiftReg[6:0], 1'b0};
                     end
                  end
                  ADDR_ACK: begin
                     if (ackSeen) begin
                        ackErr <= 1'b1;
                        state  <= STOP;
                     end else if (rwReg) begin
                        state <= RD_DATA;
                     end else begin
                        state    <= WR_DATA;
                        shiftReg <= dataReg;
                     end
                  end
                  WR_ACK: begin
                     if (ackSeen) begin
                        ackErr <= 1'b1;
                        state  <= STOP;
                     end else if (lastByte) begin
                        state <= STOP;
                     end else begin
                        byteCnt  <= byteCnt - LEN_W'(1);
                        shiftReg <= dataReg;
                        state    <= WR_DATA;
                     end
                  end
                  RD_DATA: begin
                     if (bitCnt == 3'd7) begin
                        bitCnt <= 3'd0;
                        state  <= RD_ACK;
                     end else begin
                        bitCnt <= bitCnt + 3'd1;
                     end
                  end
                  RD_ACK: begin
                     if (lastByte) begin
                        state <= STOP;
                     end else begin
                        byteCnt <= byteCnt - LEN_W'(1);
                        state   <= RD_DATA;
                     end
                  end
                  STOP: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   // Bus pin levels are a pure function of the registered state and phase.
   always_comb begin
      sdaLow = 1'b0;
      sclLow = 1'b0;
      case (state)
         START: begin
            sdaLow = phase[1];
            sclLow = (phase == 2'd3);
         end
         STOP: begin
            sdaLow = !phase[1];
            sclLow = (phase == 2'd0);
         end
         ADDR, WR_DATA: begin
            sdaLow = !shiftReg[7];
            sclLow = !phase[1];
         end
         RD_ACK: begin
            sdaLow = !lastByte;
            sclLow = !phase[1];
         end
         ADDR_ACK, WR_ACK, RD_DATA: begin
            sclLow = !phase[1];
         end
         default: begin
            sdaLow = 1'b0;
            sclLow = 1'b0;
         end
      endcase
   end

   assign sda = sdaLow ? 1'b0 : 1'bz;
   assign scl = sclLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_burst.sv
`timescale 1ns/1ps
// Bench for i2c_master_burst: behavioural I2C slave plus a transaction-level model predicting
// bus bytes, ACK bits, read data, dinReq count and burst duration.
module tb_i2c_master_burst;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dataValid = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [3:0] numBytes = 4'h0;
   logic [7:0] din;
   logic       dinReq;
   logic [7:0] dout;
   logic       doutValid;
   logic       busy;
   logic       ackErr;
   logic       done;
   wire        sda;
   wire        scl;

   logic       slaveSdaLow = 1'b0;
   logic       slaveSclLow = 1'b0;
   logic [7:0] txBytes [16];
   logic [3:0] wrIdx = 4'd0;
   int         nackFrame = -1;
   bit         stretchEn = 1'b0;

   assign sda = (slaveSdaLow && !rst) ? 1'b0 : 1'bz;
   assign scl = (slaveSclLow && !rst) ? 1'b0 : 1'bz;
   pullup (sda);
   pullup (scl);
   assign din = txBytes[wrIdx];

   i2c_master_burst #(
      .SYS_CLK_HZ(1_600_000),
      .I2C_HZ    (100_000),
      .LEN_W     (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .dataValid(dataValid),
      .rw       (rw),
      .addr     (addr),
      .numBytes (numBytes),
      .din      (din),
      .dinReq   (dinReq),
      .dout     (dout),
      .doutValid(doutValid),
      .busy     (busy),
      .ackErr   (ackErr),
      .done     (done),
      .sda      (sda),
      .scl      (scl)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Bus recorder and slave: everything it observes is appended to queues or counters.
   logic [7:0] busBytes[$];
   bit         ackBits[$];
   logic [7:0] doutQ[$];
   int         startCnt = 0, stopCnt = 0, dinReqCnt = 0, doneCnt = 0;
   int         frameNum = 0, bitIdx = 0, holdCnt = 0;
   logic [7:0] rxByte = 8'h00;
   logic [7:0] rdByte;
   bit         isRead = 1'b0, masterNacked = 1'b0;
   bit         sclPrev = 1'b1, sdaPrev = 1'b1, sdaNow, sclNow;

   always @(negedge clk) begin
      sdaNow = (sda !== 1'b0);
      sclNow = (scl !== 1'b0);
      if (rst) begin
         slaveSdaLow  = 1'b0;
         slaveSclLow  = 1'b0;
         frameNum     = 0;
         bitIdx       = 0;
         wrIdx        = 4'd0;
         isRead       = 1'b0;
         masterNacked = 1'b0;
      end else begin
         if (done === 1'b1) begin
            doneCnt++;
            wrIdx = 4'd0;
         end
         if (doutValid === 1'b1)
            doutQ.push_back(dout);
         if (dinReq === 1'b1) begin
            dinReqCnt++;
            if (wrIdx != 4'd15)
               wrIdx = wrIdx + 4'd1;
         end
         if (slaveSclLow) begin
            holdCnt++;
            if (holdCnt == 2 * DIV + 20)
               slaveSclLow = 1'b0;
         end
         if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
            startCnt++;
            frameNum     = 0;
            bitIdx       = 0;
            isRead       = 1'b0;
            masterNacked = 1'b0;
            slaveSdaLow  = 1'b0;
         end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
            stopCnt++;
         end else if (!sclPrev && sclNow) begin
            if (bitIdx < 8) begin
               rxByte = {rxByte[6:0], sdaNow};
               if (bitIdx == 7) begin
                  busBytes.push_back(rxByte);
                  if (frameNum == 0)
                     isRead = rxByte[0];
               end
            end else if (bitIdx == 8) begin
               ackBits.push_back(sdaNow);
               if (isRead && frameNum > 0 && sdaNow)
                  masterNacked = 1'b1;
            end
            bitIdx++;
         end else if (sclPrev && !sclNow) begin
            if (bitIdx == 9) begin
               bitIdx = 0;
               frameNum++;
            end
            slaveSdaLow = 1'b0;
            if (bitIdx == 8) begin
               if (frameNum == 0)
                  slaveSdaLow = (nackFrame != 0);
               else if (!isRead)
                  slaveSdaLow = (nackFrame != frameNum);
            end else if (isRead && frameNum > 0 && frameNum <= 16 && !masterNacked) begin
               rdByte      = txBytes[frameNum-1];
               slaveSdaLow = !rdByte[7-bitIdx];
            end
            if (stretchEn && frameNum == 1 && bitIdx == 3) begin
               slaveSclLow = 1'b1;
               holdCnt     = 0;
            end
         end
      end
      sclPrev = sclNow;
      sdaPrev = sdaNow;
   end

   task automatic applyStimulus(input bit r, input logic [6:0] a, input int n);
      rw        = r;
      addr      = a;
      numBytes  = 4'(n - 1);
      dataValid = 1'b1;
      @(negedge clk);
      dataValid = 1'b0;
   endtask

   // One full transaction; txBytes holds write data or the slave's read data.
   task automatic runTxn(input bit r, input logic [6:0] a, input int n, input int nack,
                         input bit stretch, input bit poke);
      int b0, a0, d0, s0, p0, r0, c0, k, frames, expDur, cnt, expCnt;
      logic [7:0] e;
      nackFrame = nack;
      stretchEn = stretch;
      b0 = busBytes.size(); a0 = ackBits.size(); d0 = doutQ.size();
      s0 = startCnt; p0 = stopCnt; r0 = dinReqCnt; c0 = doneCnt;
      applyStimulus(r, a, n);
      checkOutput("busy after accept", busy, 1);
      checkOutput("ackErr cleared on accept", ackErr, 0);
      k = 0;
      while (done !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
         if (poke && k == 100) begin
            rw = ~r; addr = ~a; numBytes = 4'd0; dataValid = 1'b1;
         end
         if (poke && k == 101) begin
            dataValid = 1'b0; rw = r; addr = a; numBytes = 4'(n - 1);
         end
      end
      frames = (nack == 0) ? 1 : ((!r && nack > 0) ? 1 + nack : 1 + n);
      expDur = (2 + 9 * frames) * 4 * DIV + ((stretch && frames > 1) ? 20 : 0);
      checkOutput("done seen", done, 1);
      checkOutput("duration", k, expDur);
      checkOutput("ackErr at done", ackErr, (nack >= 0) ? 1 : 0);
      checkOutput("busy at done", busy, 0);
      dataValid = 1'b1;
      @(negedge clk);
      dataValid = 1'b0;
      checkOutput("command with done ignored", busy, 0);
      @(negedge clk);

      checkOutput("start count", startCnt - s0, 1);
      checkOutput("stop count", stopCnt - p0, 1);
      checkOutput("done count", doneCnt - c0, 1);
      expCnt = r ? 0 : (((frames - 1) < (n - 1)) ? frames - 1 : n - 1);
      checkOutput("dinReq pulses", dinReqCnt - r0, expCnt);

      cnt = busBytes.size() - b0;
      checkOutput("bus byte count", cnt, frames);
      for (int i = 0; i < frames && i < cnt; i++) begin
         e = (i == 0) ? {a, r} : txBytes[i-1];
         checkOutput($sformatf("bus byte %0d", i), busBytes[b0+i], e);
      end
      cnt = ackBits.size() - a0;
      checkOutput("ack bit count", cnt, frames);
      for (int i = 0; i < frames && i < cnt; i++) begin
         bit eb;
         if (i == 0)  eb = (nack == 0);
         else if (r)  eb = (i == n);
         else         eb = (nack == i);
         checkOutput($sformatf("ack bit %0d", i), ackBits[a0+i], eb);
      end
      expCnt = (r && nack != 0) ? n : 0;
      cnt = doutQ.size() - d0;
      checkOutput("doutValid count", cnt, expCnt);
      for (int i = 0; i < expCnt && i < cnt; i++)
         checkOutput($sformatf("read byte %0d", i), doutQ[d0+i], txBytes[i]);
   endtask

   initial begin
      int n, nack, sel;
      bit r;
      for (int i = 0; i < 16; i++) txBytes[i] = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset ackErr", ackErr, 0);
      checkOutput("reset dinReq", dinReq, 0);
      checkOutput("reset doutValid", doutValid, 0);
      checkOutput("reset dout", dout, 8'h00);
      checkOutput("reset sda", sda, 1);
      checkOutput("reset scl", scl, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] burst write");
      txBytes[0] = 8'h11; txBytes[1] = 8'h22;
      runTxn(1'b0, 7'h50, 2, -1, 1'b0, 1'b0);

      $display("[TB] address NACK");
      txBytes[0] = 8'h5A;
      runTxn(1'b0, 7'h21, 1, 0, 1'b0, 1'b0);

      $display("[TB] stretched write with ignored mid-burst command");
      txBytes[0] = 8'h11; txBytes[1] = 8'h22;
      runTxn(1'b0, 7'h50, 2, -1, 1'b1, 1'b1);

      $display("[TB] burst read");
      txBytes[0] = 8'hA5; txBytes[1] = 8'h3C; txBytes[2] = 8'hFF;
      runTxn(1'b1, 7'h50, 3, -1, 1'b0, 1'b0);

      $display("[TB] reset during read data");
      applyStimulus(1'b1, 7'h50, 3);
      for (int k = 1; k <= 175; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid reset busy", busy, 0);
      checkOutput("mid reset dout", dout, 8'h00);
      checkOutput("mid reset done", done, 0);
      checkOutput("mid reset sda", sda, 1);
      checkOutput("mid reset scl", scl, 1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] randomized bursts");
      for (int t = 0; t < 10; t++) begin
         r = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) txBytes[i] = 8'($urandom);
         sel  = $urandom_range(0, 5);
         nack = -1;
         if (sel == 0)
            nack = 0;
         else if (sel == 1 && !r)
            nack = $urandom_range(1, n);
         runTxn(r, 7'($urandom_range(0, 127)), n, nack, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
